// File: rtl/point_byte_encoder.sv
// point_byte_encoder: canonicalises an affine point mod p and
// streams it out as little-endian bytes (Ed448 or raw x||y).
`ifndef P448
`define P448 ({448{1'b1}} ^ (448'd1 << 224))
`endif

module point_byte_encoder #(
    parameter int          N = 448,
    parameter logic [N-1:0] P = `P448
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] px,
    input  logic [N-1:0] py,
    input  logic         encode,
    input  logic         res_valid,
    output logic         res_ready,
    output logic [7:0]   byte_data,
    output logic         byte_valid,
    input  logic         byte_ready,
    output logic         byte_last,
    output logic         busy
);

    localparam logic [6:0] NB       = 7'(N / 8);
    localparam logic [6:0] LAST_ENC = 7'(N / 8);
    localparam logic [6:0] LAST_RAW = 7'(2 * (N / 8) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        SEND   = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [N-1:0] x_q;
    logic [N-1:0] y_q;
    logic         enc_q;
    logic [6:0]   cnt;
    logic [N-1:0] x_red;
    logic [N-1:0] y_red;
    logic [7:0]   sel;
    logic [6:0]   last_idx;
    logic         capture;
    logic         take;

    assign capture  = (state_q == IDLE) && res_valid && !res_ready;
    assign take     = byte_valid && byte_ready;
    assign busy     = (state_q != IDLE);
    assign x_red    = (x_q >= P) ? x_q - P : x_q;
    assign y_red    = (y_q >= P) ? y_q - P : y_q;
    assign last_idx = enc_q ? LAST_ENC : LAST_RAW;

    // Byte selected by the counter for the active frame format.
    always_comb begin
        sel = '0;
        if (enc_q) begin
            if (cnt < NB) sel = y_q[8*32'(cnt) +: 8];
            else          sel = {x_q[0], 7'b0};
        end else begin
            if (cnt < NB) sel = x_q[8*32'(cnt) +: 8];
            else          sel = y_q[8*32'(cnt - NB) +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (capture) state_d = REDUCE;
            REDUCE:  state_d = SEND;
            SEND:    if (take && byte_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Four-phase acknowledge: set on capture, cleared once valid drops.
    always_ff @(posedge clk) begin
        if (rst)             res_ready <= 1'b0;
        else if (!res_valid) res_ready <= 1'b0;
        else if (capture)    res_ready <= 1'b1;
    end

    // Capture, single-step reduction and byte presentation.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            enc_q      <= 1'b0;
            cnt        <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (capture) begin
                        x_q   <= px;
                        y_q   <= py;
                        enc_q <= encode;
                    end
                end
                REDUCE: begin
                    x_q <= x_red;
                    y_q <= y_red;
                    cnt <= '0;
                end
                SEND: begin
                    if (!byte_valid || (byte_ready && !byte_last)) begin
                        byte_data  <= sel;
                        byte_last  <= (cnt == last_idx);
                        byte_valid <= 1'b1;
                        cnt        <= cnt + 7'd1;
                    end else if (take) begin
                        byte_data  <= '0;
                        byte_last  <= 1'b0;
                        byte_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_point_byte_encoder.sv
// tb_point_byte_encoder: directed and randomized frames checked
// against a byte-queue reference model of the point encoding.
`define CHK(t, g, w) chk(t, 448'(g), 448'(w))

module tb_point_byte_encoder;

    localparam logic [447:0] PREF = {448{1'b1}} - (448'd1 << 224);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [447:0] px = '0;
    logic [447:0] py = '0;
    logic         encode = 1'b0;
    logic         res_valid = 1'b0;
    logic         res_ready;
    logic [7:0]   byte_data;
    logic         byte_valid;
    logic         byte_ready = 1'b0;
    logic         byte_last;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] ref_q[$];

    point_byte_encoder dut (
        .clk(clk), .rst(rst), .px(px), .py(py), .encode(encode),
        .res_valid(res_valid), .res_ready(res_ready),
        .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .byte_last(byte_last), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && byte_valid) begin
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $error("FAIL mon_busy: byte_valid without busy");
            end
        end
    end

    task automatic chk(input string tag, input logic [447:0] got,
                       input logic [447:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [447:0] rnd448();
        logic [447:0] r = '0;
        for (int i = 0; i < 14; i++) r = {r[415:0], 32'($urandom)};
        return r;
    endfunction

    function automatic void model(input logic [447:0] x, input logic [447:0] y,
                                  input logic e);
        logic [447:0] xr, yr, t;
        xr = (x >= PREF) ? x - PREF : x;
        yr = (y >= PREF) ? y - PREF : y;
        exp_q.delete();
        if (!e) begin
            t = xr;
            for (int k = 0; k < 56; k++) begin
                exp_q.push_back(t[7:0]);
                t = t >> 8;
            end
        end
        t = yr;
        for (int k = 0; k < 56; k++) begin
            exp_q.push_back(t[7:0]);
            t = t >> 8;
        end
        if (e) exp_q.push_back(xr[0] ? 8'h80 : 8'h00);
    endfunction

    task automatic run_frame(input logic [447:0] x, input logic [447:0] y,
                             input logic e, input int pct, input int abort_at);
        int n, idx, cyc;
        bit done, stall, rdy, aborted;
        logic [7:0] pd;
        logic pl;
        model(x, y, e);
        got_q.delete();
        px = x; py = y; encode = e; res_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!res_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        `CHK("capture", res_ready, 1'b1);
        res_valid = 1'b0;
        px = rnd448(); py = rnd448(); encode = ~e;
        `CHK("lat0_valid", byte_valid, 1'b0);
        `CHK("lat0_busy", busy, 1'b1);
        @(negedge clk);
        `CHK("lat1_valid", byte_valid, 1'b0);
        `CHK("rr_drop", res_ready, 1'b0);
        @(negedge clk);
        `CHK("lat2_valid", byte_valid, 1'b1);
        idx = 0; cyc = 0; done = 0; stall = 0; aborted = 0;
        pd = '0; pl = 1'b0;
        while (!done && cyc < 3000) begin
            if (stall) begin
                `CHK("stall_valid", byte_valid, 1'b1);
                `CHK("stall_data", byte_data, pd);
                `CHK("stall_last", byte_last, pl);
            end
            if (byte_valid) begin
                if (idx < exp_q.size())
                    `CHK($sformatf("data[%0d]", idx), byte_data, exp_q[idx]);
                `CHK($sformatf("last[%0d]", idx), byte_last,
                     idx == exp_q.size() - 1);
                rdy = ($urandom_range(0, 99) < pct);
                byte_ready = rdy;
                stall = !rdy;
                pd = byte_data;
                pl = byte_last;
                if (rdy) begin
                    got_q.push_back(byte_data);
                    if (idx == abort_at) begin
                        aborted = 1;
                        done = 1;
                    end
                    if (byte_last) done = 1;
                    idx++;
                end
            end else begin
                byte_ready = 1'($urandom_range(0, 1));
                stall = 0;
            end
            if (!aborted) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!aborted) begin
            byte_ready = 1'b0;
            `CHK("timeout", cyc < 3000, 1'b1);
            `CHK("count", idx, exp_q.size());
            `CHK("end_valid", byte_valid, 1'b0);
            `CHK("end_busy", busy, 1'b0);
        end
    endtask

    initial begin
        int frames, drops, hits, diffs;
        bit seen;
        logic [447:0] bx, by, x, y;
        logic e;

        repeat (2) @(negedge clk);
        `CHK("rst_valid", byte_valid, 1'b0);
        `CHK("rst_ready", res_ready, 1'b0);
        `CHK("rst_last", byte_last, 1'b0);
        `CHK("rst_data", byte_data, 8'h00);
        `CHK("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(PREF + 448'd5, 448'd7, 1'b0, 100, -1);
        `CHK("raw_b0", got_q[0], 8'h05);
        `CHK("raw_b56", got_q[56], 8'h07);
        `CHK("raw_len", got_q.size(), 112);

        run_frame(448'd3, 448'h0102, 1'b1, 100, -1);
        `CHK("enc_b0", got_q[0], 8'h02);
        `CHK("enc_b1", got_q[1], 8'h01);
        `CHK("enc_b56", got_q[56], 8'h80);
        `CHK("enc_len", got_q.size(), 57);
        run_frame(448'd2, 448'h0102, 1'b1, 100, -1);
        `CHK("enc_even_b56", got_q[56], 8'h00);

        for (int m = 0; m < 2; m++) begin
            x = rnd448();
            y = rnd448();
            run_frame(x, y, m[0], 100, -1);
            ref_q = got_q;
            run_frame(x, y, m[0], 30, -1);
            diffs = 0;
            foreach (ref_q[i]) if (i < got_q.size() && got_q[i] !== ref_q[i]) diffs++;
            `CHK("bp_len", got_q.size(), ref_q.size());
            `CHK("bp_same", diffs, 0);
        end

        for (int r = 0; r < 8; r++) begin
            unique case (r % 4)
                0: x = rnd448();
                1: x = PREF + 448'($urandom);
                2: x = PREF - 448'd1;
                default: x = {448{1'b1}};
            endcase
            y = (r % 3 == 0) ? PREF : rnd448();
            e = 1'($urandom_range(0, 1));
            run_frame(x, y, e, 60, -1);
        end

        model(448'd5, 448'd9, 1'b1);
        px = 448'd5; py = 448'd9; encode = 1'b1;
        res_valid = 1'b1; byte_ready = 1'b1;
        frames = 0; drops = 0; seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (seen && !res_ready) drops++;
            if (res_ready) seen = 1;
            if (byte_valid && byte_last) frames++;
        end
        `CHK("hs_seen", seen, 1'b1);
        `CHK("hs_frames", frames, 1);
        `CHK("hs_drops", drops, 0);
        `CHK("hs_busy", busy, 1'b0);
        res_valid = 1'b0; byte_ready = 1'b0;
        @(negedge clk);
        `CHK("hs_release", res_ready, 1'b0);
        run_frame(448'd5, 448'd9, 1'b1, 100, -1);
        hits = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (byte_valid) hits++;
        end
        `CHK("hs_no_extra", hits, 0);

        run_frame(rnd448(), rnd448(), 1'b0, 100, 20);
        `CHK("abort_idx", got_q.size(), 21);
        @(negedge clk);
        byte_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        `CHK("mid_valid", byte_valid, 1'b0);
        `CHK("mid_ready", res_ready, 1'b0);
        `CHK("mid_busy", busy, 1'b0);
        `CHK("mid_last", byte_last, 1'b0);
        `CHK("mid_data", byte_data, 8'h00);
        hits = 0;
        for (int i = 0; i < 120; i++) begin
            byte_ready = 1'b1;
            @(negedge clk);
            if (byte_valid || byte_last) hits++;
        end
        byte_ready = 1'b0;
        `CHK("mid_silent", hits, 0);
        run_frame(PREF + 448'd1, 448'h1234, 1'b0, 50, -1);

        bx = 448'h4f1970c66bed0ded221d15a622bf36da9e146570470f1767ea6de324a3d3a46412ae1af72ab66511433b80e18b00938e2626a82bc70cc05e;
        by = 448'h693f46716eb6bc248876203756c9c7624bea73736ca3984087789c1e05a0c2d73ad3ff1ce67c39c4fdbd132c4ed7c8ad9808795bf230fa14;
        run_frame(bx, by, 1'b1, 70, -1);
        `CHK("ref_b0", got_q[0], 8'h14);
        `CHK("ref_b55", got_q[55], 8'h69);
        `CHK("ref_b56", got_q[56], 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
